// File: rtl/cpu_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arbiter_if
// Description : Bundle of fetch, data and memory-side signals for the CPU
//               memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              err;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_done, d_rdata, d_done,
        output mem_en, mem_we, mem_addr, mem_wdata, err, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_done, d_rdata, d_done,
        input  mem_en, mem_we, mem_addr, mem_wdata, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arbiter
// Description : Round-robin arbiter sharing one memory port between fetch and
//               data requesters, with per-access timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  wire logic       clk,
    input  wire logic       rst,
    cpu_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            r_state,     w_state_nxt;
    logic              r_last_d,    w_last_d_nxt;
    logic              r_gnt_d,     w_gnt_d_nxt;
    logic [7:0]        r_cnt,       w_cnt_nxt;
    logic              r_mem_en,    w_mem_en_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [DATA_W-1:0] r_d_rdata,   w_d_rdata_nxt;
    logic              r_if_done,   w_if_done_nxt;
    logic              r_d_done,    w_d_done_nxt;
    logic              r_err,       w_err_nxt;
    logic              r_busy,      w_busy_nxt;
    logic [DATA_W-1:0] w_rdata;
    logic              w_pick_d;

    // On a tie the requester that did not win last time gets the port.
    assign w_pick_d = bus.d_req & (~bus.if_req | ~r_last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_d    <= 1'b0;
            r_gnt_d     <= 1'b0;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_d    <= w_last_d_nxt;
            r_gnt_d     <= w_gnt_d_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_if_done   <= w_if_done_nxt;
            r_d_done    <= w_d_done_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_d_nxt    = r_last_d;
        w_gnt_d_nxt     = r_gnt_d;
        w_cnt_nxt       = r_cnt;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_if_done_nxt   = 1'b0;
        w_d_done_nxt    = 1'b0;
        w_err_nxt       = 1'b0;
        w_rdata         = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.if_req | bus.d_req) begin
                    w_state_nxt  = S_ACCESS;
                    w_gnt_d_nxt  = w_pick_d;
                    w_last_d_nxt = w_pick_d;
                    w_cnt_nxt    = '0;
                    w_mem_en_nxt = 1'b1;
                    if (w_pick_d) begin
                        w_mem_we_nxt    = bus.d_we;
                        w_mem_addr_nxt  = bus.d_addr;
                        w_mem_wdata_nxt = bus.d_wdata;
                    end else begin
                        w_mem_we_nxt    = 1'b0;
                        w_mem_addr_nxt  = bus.if_addr;
                        w_mem_wdata_nxt = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (bus.mem_ready || (r_cnt == c_WAIT_LAST)) begin
                    // A store or an aborted access reports zero read data.
                    if (bus.mem_ready && !r_mem_we) begin
                        w_rdata = bus.mem_rdata;
                    end
                    if (r_gnt_d) begin
                        w_d_rdata_nxt = w_rdata;
                        w_d_done_nxt  = 1'b1;
                    end else begin
                        w_if_rdata_nxt = w_rdata;
                        w_if_done_nxt  = 1'b1;
                    end
                    w_err_nxt    = ~bus.mem_ready;
                    w_mem_en_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_mem_en_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_done   = r_if_done;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_done    = r_d_done;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_arbiter
// Description : Scoreboard bench for cpu_mem_arbiter with a delay-programmable
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_arbiter;
    localparam int MAX_WAIT = 15;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          cycles;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   mem_delay;
    bit   mem_noise;
    int   d_done_cnt;
    exp_t sb[$];

    cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return 32'hA5000000 ^ (a * 3 + 32'd1);
    endfunction

    function automatic exp_t mk(input bit is_d, input bit we, input logic [31:0] a,
                                input logic [31:0] wd, input bit err, input int cyc);
        exp_t e;
        e.is_d = is_d; e.we = we; e.addr = a; e.wdata = wd; e.err = err; e.cycles = cyc;
        e.rdata = (we || err) ? 32'h0 : mem_word(a);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.if_done) bus.if_req = 1'b0;
            if (bus.d_done)  bus.d_req  = 1'b0;
            if (sb.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Memory model: answers after mem_delay extra ACCESS cycles.
    initial begin
        int acc;
        acc = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_en) begin
                acc++;
                if (acc == mem_delay + 1) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end else begin
                acc = 0;
                bus.mem_ready = mem_noise;
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Scoreboard monitor: grant fields, completion data, gaps and exclusivity.
    initial begin
        bit   prev_en, prev_done, unstable;
        int   acc;
        exp_t e;
        prev_en = 0; prev_done = 0; unstable = 0; acc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 0; prev_done = 0; acc = 0;
                continue;
            end
            if (prev_done) begin
                checks++;
                if (bus.mem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL grant_in_done: mem_en=%0b required 0", bus.mem_en);
                end
            end
            if (bus.mem_en) begin
                if (!prev_en) begin
                    acc = 1; unstable = 0;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_grant: addr=%h with empty scoreboard", bus.mem_addr);
                    end else if (bus.mem_addr !== sb[0].addr || bus.mem_we !== sb[0].we ||
                                 (sb[0].we && bus.mem_wdata !== sb[0].wdata)) begin
                        errors++;
                        $display("FAIL grant_fields: addr=%h we=%0b wdata=%h required addr=%h we=%0b wdata=%h",
                                 bus.mem_addr, bus.mem_we, bus.mem_wdata, sb[0].addr, sb[0].we, sb[0].wdata);
                    end
                end else begin
                    acc++;
                    if (sb.size() != 0 && (bus.mem_addr !== sb[0].addr || bus.mem_we !== sb[0].we ||
                        (sb[0].we && bus.mem_wdata !== sb[0].wdata)))
                        unstable = 1;
                end
            end
            if (bus.err && !(bus.if_done || bus.d_done)) begin
                checks++;
                errors++;
                $display("FAIL err_without_done: err=1 required 0");
            end
            if (bus.if_done || bus.d_done) begin
                checks++;
                if (bus.if_done && bus.d_done) begin
                    errors++;
                    $display("FAIL both_done: if_done=1 d_done=1 required at most one");
                end
                if (bus.d_done) d_done_cnt++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: if_done=%0b d_done=%0b", bus.if_done, bus.d_done);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (bus.d_done !== e.is_d) begin
                        errors++;
                        $display("FAIL done_owner: d_done=%0b required %0b", bus.d_done, e.is_d);
                    end
                    checks++;
                    if ((e.is_d ? bus.d_rdata : bus.if_rdata) !== e.rdata) begin
                        errors++;
                        $display("FAIL rdata: got %h required %h",
                                 e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
                    end
                    checks++;
                    if (bus.err !== e.err || bus.busy !== 1'b1) begin
                        errors++;
                        $display("FAIL done_flags: err=%0b busy=%0b required err=%0b busy=1",
                                 bus.err, bus.busy, e.err);
                    end
                    checks++;
                    if (acc != e.cycles || unstable) begin
                        errors++;
                        $display("FAIL access_cycles: %0d cycles unstable=%0b required %0d stable",
                                 acc, unstable, e.cycles);
                    end
                end
            end
            prev_en   = bus.mem_en;
            prev_done = bus.if_done | bus.d_done;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0;
        do_reset();
        mem_noise = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.if_done, bus.d_done, bus.mem_en, bus.mem_we, bus.err, bus.busy} !== 6'b0 ||
                bus.if_rdata !== '0 || bus.d_rdata !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
                errors++;
                $display("FAIL reset_idle: flags=%b if_rdata=%h d_rdata=%h mem_addr=%h required all 0",
                         {bus.if_done, bus.d_done, bus.mem_en, bus.mem_we, bus.err, bus.busy},
                         bus.if_rdata, bus.d_rdata, bus.mem_addr);
            end
        end
        mem_noise = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_delay = 255;
        sb.push_back(mk(1, 1, 32'h200, 32'h0000CAFE, 0, 1));
        bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h0000CAFE; bus.d_req = 1;
        tick(); tick(); tick();
        rst = 1'b1; bus.d_req = 0;
        tick();
        rst = 1'b0;
        sb.delete();
        checks++;
        if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0 || bus.d_done !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: mem_en=%0b busy=%0b d_done=%0b mem_we=%0b required 0",
                     bus.mem_en, bus.busy, bus.d_done, bus.mem_we);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.d_done !== 1'b0 || bus.if_done !== 1'b0 || bus.mem_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet: d_done=%0b if_done=%0b mem_en=%0b required 0",
                         bus.d_done, bus.if_done, bus.mem_en);
            end
        end
    endtask

    task automatic test_fetch();
        mem_delay = 0;
        sb.push_back(mk(0, 0, 32'h40, 32'h0, 0, 1));
        bus.if_addr = 32'h40; bus.if_req = 1;
        tick();
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch_access: mem_en=%0b addr=%h we=%0b required 1 00000040 0",
                     bus.mem_en, bus.mem_addr, bus.mem_we);
        end
        tick();
        checks++;
        if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'hDEADBEEF || bus.err !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: if_done=%0b rdata=%h err=%0b mem_en=%0b required 1 deadbeef 0 0",
                     bus.if_done, bus.if_rdata, bus.err, bus.mem_en);
        end
        bus.if_req = 0;
        tick();
        checks++;
        if (bus.if_done !== 1'b0 || bus.if_rdata !== 32'hDEADBEEF || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_after: if_done=%0b rdata=%h busy=%0b required 0 deadbeef 0",
                     bus.if_done, bus.if_rdata, bus.busy);
        end
    endtask

    task automatic test_store();
        bit ok;
        mem_delay = 1;
        sb.push_back(mk(1, 0, 32'h80, 32'h0, 0, 2));
        bus.d_we = 0; bus.d_addr = 32'h80; bus.d_req = 1;
        drain(40, ok);
        checks++;
        if (!ok || bus.d_rdata !== mem_word(32'h80)) begin
            errors++;
            $display("FAIL load_80: done=%0b d_rdata=%h required 1 %h", ok, bus.d_rdata, mem_word(32'h80));
        end
        mem_delay = 4;
        sb.push_back(mk(1, 1, 32'h100, 32'h12345678, 0, 5));
        bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'h12345678; bus.d_req = 1;
        drain(40, ok);
        checks++;
        if (!ok || bus.d_rdata !== 32'h0 || bus.d_done !== 1'b0) begin
            errors++;
            $display("FAIL store_100: done=%0b d_rdata=%h d_done=%0b required 1 0 0", ok, bus.d_rdata, bus.d_done);
        end
        bus.d_we = 0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        mem_delay = 1;
        for (int r = 0; r < 2; r++) begin
            sb.push_back(mk(1, 0, 32'h300 + r * 8, 32'h0, 0, 2));
            sb.push_back(mk(0, 0, 32'h304 + r * 8, 32'h0, 0, 2));
            bus.d_addr = 32'h300 + r * 8; bus.if_addr = 32'h304 + r * 8;
            bus.d_req = 1; bus.if_req = 1;
            drain(60, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL tie_drain_%0d: queue=%0d busy=%0b required empty idle", r, sb.size(), bus.busy);
            end
        end
        sb.push_back(mk(1, 0, 32'h310, 32'h0, 0, 2));
        bus.d_addr = 32'h310; bus.d_req = 1;
        drain(40, ok);
        sb.push_back(mk(0, 0, 32'h314, 32'h0, 0, 2));
        sb.push_back(mk(1, 0, 32'h318, 32'h0, 0, 2));
        bus.if_addr = 32'h314; bus.d_addr = 32'h318;
        bus.d_req = 1; bus.if_req = 1;
        drain(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tie_if_first: queue=%0d busy=%0b required empty idle", sb.size(), bus.busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        mem_delay = 255;
        sb.push_back(mk(0, 0, 32'h44, 32'h0, 1, MAX_WAIT));
        bus.if_addr = 32'h44; bus.if_req = 1;
        drain(60, ok);
        checks++;
        if (!ok || bus.if_rdata !== 32'h0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL timeout: done=%0b if_rdata=%h err=%0b required 1 0 0", ok, bus.if_rdata, bus.err);
        end
        mem_delay = 2;
        sb.push_back(mk(1, 0, 32'h48, 32'h0, 0, 3));
        bus.d_addr = 32'h48; bus.d_req = 1;
        drain(40, ok);
        checks++;
        if (!ok || bus.d_rdata !== mem_word(32'h48)) begin
            errors++;
            $display("FAIL after_timeout: done=%0b d_rdata=%h required 1 %h", ok, bus.d_rdata, mem_word(32'h48));
        end
    endtask

    task automatic test_drop();
        bit ok;
        int base;
        mem_delay = 5;
        base = d_done_cnt;
        sb.push_back(mk(1, 0, 32'h50, 32'h0, 0, 6));
        bus.d_addr = 32'h50; bus.d_req = 1;
        tick();
        tick();
        bus.d_req = 0;
        drain(40, ok);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (!ok || d_done_cnt != base + 1) begin
            errors++;
            $display("FAIL drop_req: done=%0b d_done pulses=%0d required 1", ok, d_done_cnt - base);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; d_done_cnt = 0;
        mem_delay = 0; mem_noise = 0; rst = 1'b1;
        test_reset();
        test_reset_mid();
        test_fetch();
        test_store();
        test_back_to_back();
        test_timeout();
        test_drop();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares the CPU's single-port memory between two requesters: instruction fetch (IF) and data load/store (D).
- Arbitrates between them, sequences one memory transaction at a time through an IDLE/ACCESS/DONE state machine, returns read data and a one-cycle done pulse to the winning requester, and aborts stalled accesses with a timeout.
- Sits between the CPU core's fetch/data stages and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 15, maximum ACCESS cycles (mem_en high) before a transaction is aborted; legal range 1..255.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_done is sampled.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched word; valid in the if_done cycle.
- if_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held high until d_done is sampled.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid in the d_done cycle.
- d_done  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready = 1.
- mem_ready  in  1  memory completion, sampled only while mem_en = 1.
- err  out  1  high with done only if the transaction timed out.
- busy  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (checked at the rising edge):
  - State goes to IDLE and last_grant goes to IF.
  - All outputs go to 0, including rdata registers, mem_* registers and the wait counter.
  - Reset mid-transaction abandons it silently: no done pulse, mem_en low on the next cycle.
- All outputs are registered.
- IDLE:
  - Only d_req high: grant D.
  - Only if_req high: grant IF.
  - Both high: grant the requester not in last_grant (round-robin). Since last_grant resets to IF, D wins the first tie.
  - On a grant: latch addr/we/wdata into mem_* (mem_we = 0 for IF), set mem_en = 1, clear the wait counter, update last_grant, go to ACCESS.
  - Neither high: stay in IDLE.
- ACCESS:
  - mem_en and mem_* are held constant.
  - mem_ready = 1 at an edge:
    - Capture mem_rdata into the granted requester's rdata register; for a store, capture 0.
    - Set that requester's done = 1 and err = 0, drop mem_en/mem_we, go to DONE.
  - mem_ready = 0 and counter == MAX_WAIT-1: abort.
    - Set done = 1 and err = 1, rdata = 0, drop mem_en, go to DONE.
  - Otherwise: counter += 1.
  - mem_en is therefore never high for more than MAX_WAIT consecutive cycles.
- DONE:
  - Lasts exactly one cycle; done (and err) are high only here.
  - No grant is made in DONE.
  - Next state is always IDLE. done and err clear, but rdata holds its value until that requester's next completion.
- Requester rules:
  - A requester drops req on the edge at which it samples done = 1.
  - Dropping req during ACCESS does not cancel the transaction; done still pulses.
  - The non-granted requester's req stays pending and is served next.
- Latency:
  - req sampled at edge 0 → mem_en high from edge 1.
  - mem_ready sampled at edge n (n ≥ 1) → done high from edge n+1 for one cycle → IDLE from edge n+2.
  - Minimum 3 cycles per transaction; peak throughput 1 transaction per 3 cycles.
- mem_ready while mem_en = 0 is ignored.
- if_done and d_done are never high in the same cycle.

Test Plan:
- Reset, then idle with no requests for 5 cycles → all outputs 0 and busy = 0; pulse Reset during ACCESS → IDLE next cycle, no done pulse.
- if_req alone, if_addr = 0x40, memory returns mem_rdata = 0xDEADBEEF with mem_ready on the first ACCESS cycle → mem_en high for exactly 1 cycle with mem_addr = 0x40 and mem_we = 0; if_done pulses 2 cycles after req with if_rdata = 0xDEADBEEF and err = 0.
- d_req store, d_addr = 0x100, d_wdata = 0x12345678, mem_ready delayed 4 cycles → mem_en high for 5 cycles with mem_we = 1 and stable mem_addr/mem_wdata; d_done pulses once, d_rdata = 0.
- if_req and d_req raised together after reset → D granted first, IF second; repeat the tie → order alternates IF, D; no grant is made in any DONE cycle.
- mem_ready held low with MAX_WAIT = 15 → mem_en high for exactly 15 cycles, then done = 1 and err = 1 with rdata = 0 for one cycle; the next request completes normally with err = 0.
- d_req dropped in the 2nd ACCESS cycle, mem_ready arrives later → transaction still completes and d_done pulses once.
